regfile_32x64: RTL and testbench

- 32-entry x 64-bit register file for the 64-bit ARM datapath.
- Sits directly downstream of the write-address decode tree. The 5-bit write register number is decoded to a one-hot 32-bit write-enable, gated by RegWrite, and that enable selects which register captures WriteData on the clock edge.
- Two combinational read ports feed the ALU operand muxes.
- X31 is hardwired to zero (XZR).

---
 rtl/regfile_32x64.sv | 77 +++++++
 tb/tb_regfile_32x64.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file with a hardwired-zero register and two combinational read ports.
// The write-enable is a two-level enabled decoder tree; BYPASS selects write-through reads.
module regfile_32x64 #(
   parameter int NREG     = 32,
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 31,
   parameter bit BYPASS   = 1'b0,
   localparam int AW      = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWrite,
   input  logic [AW-1:0]    WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [AW-1:0]    ReadRegister1,
   input  logic [AW-1:0]    ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2
);

   localparam int LOW_W = (AW > 3) ? 3 : 1;
   localparam int TOP_W = AW - LOW_W;
   localparam int TOP_N = 1 << TOP_W;
   localparam int LOW_N = 1 << LOW_W;
   localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

   logic [TOP_N-1:0] w_top_en;
   logic [NREG-1:0]  w_wen;
   logic [WIDTH-1:0] r_regs [NREG];

   // AND-gating (not a mux) keeps enables at 0 when RegWrite=0 even if the address is X.
   genvar gi, gj;
   generate
      for (gi = 0; gi < TOP_N; gi++) begin : g_top
         assign w_top_en[gi] = RegWrite & (WriteRegister[AW-1:LOW_W] == TOP_W'(gi));
         for (gj = 0; gj < LOW_N; gj++) begin : g_low
            assign w_wen[gi*LOW_N + gj] = w_top_en[gi] & (WriteRegister[LOW_W-1:0] == LOW_W'(gj));
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (i != ZERO_REG && w_wen[i]) begin
               r_regs[i] <= WriteData;
            end
         end
      end
   end

   // The zero-register override comes last so it also beats the bypass path.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [AW-1:0]    w_addr;
         logic [WIDTH-1:0] w_data;
         assign w_addr = (gi == 0) ? ReadRegister1 : ReadRegister2;
         always_comb begin
            w_data = r_regs[w_addr];
            if (BYPASS && RegWrite && (WriteRegister == w_addr)) begin
               w_data = WriteData;
            end
            if (w_addr == ZADDR) begin
               w_data = '0;
            end
         end
      end
   endgenerate

   assign ReadData1 = g_rd[0].w_data;
   assign ReadData2 = g_rd[1].w_data;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64: one instance without bypass, one with bypass, sharing all inputs.
module tb_regfile_32x64;

   logic        clk = 1'b0;
   logic        reset, RegWrite;
   logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
   logic [63:0] WriteData;
   logic [63:0] rd1, rd2, bp1, bp2;

   int checks = 0;
   int errors = 0;
   logic [63:0] model [32];

   localparam logic [63:0] B = 64'hA5A5_0000_0000_0000;

   always #5 clk = ~clk;

   regfile_32x64 #(.BYPASS(1'b0)) dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(rd1), .ReadData2(rd2)
   );

   regfile_32x64 #(.BYPASS(1'b1)) dut_byp (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(bp1), .ReadData2(bp2)
   );

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic [4:0]  ra1, ra2;
      logic [63:0] pre1, pre2, post1, post2, byp1;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int a = 0; a < 32; a++) begin
         ReadRegister1 = 5'(a);
         ReadRegister2 = 5'(31 - a);
         #1;
         check($sformatf("%s rd1[%0d]", tag, a), rd1, model[a]);
         check($sformatf("%s rd2[%0d]", tag, 31 - a), rd2, model[31 - a]);
      end
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
      @(negedge clk);
      RegWrite = 1'b1;
      WriteRegister = addr;
      WriteData = data;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      $display("write X%0d <= %h", addr, data);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[1] = '{1'b0, 5'd5, 64'h1234, 5'd5, 5'd5, B + 5, B + 5, B + 5, B + 5, B + 5};
      vecs[2] = '{1'b1, 5'd7, 64'h1111, 5'd7, 5'd6, B + 7, B + 6, 64'h1111, B + 6, 64'h1111};
      vecs[3] = '{1'b1, 5'd7, 64'h2222, 5'd7, 5'd7, 64'h1111, 64'h1111, 64'h2222, 64'h2222, 64'h2222};
      vecs[4] = '{1'b1, 5'd0, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd31, B, 64'd0,
                  64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF};
      vecs[5] = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 64'd0, B + 30, 64'd0, B + 30, 64'd0};

      reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset sweep
      check_all("reset");

      // Write/readback of X0..X30 with full-file check after each write
      for (int i = 0; i <= 30; i++) begin
         do_write(5'(i), B + 64'(i));
         model[i] = B + 64'(i);
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(30 - i);
         #1;
         check($sformatf("wr%0d rd1", i), rd1, B + 64'(i));
         check($sformatf("wr%0d rd2", i), rd2, (30 - i <= i) ? B + 64'(30 - i) : 64'd0);
         check_all($sformatf("after wr%0d", i));
      end

      // Table: zero register, RegWrite=0, read-during-write with and without bypass
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         RegWrite = vecs[v].we;
         WriteRegister = vecs[v].waddr;
         WriteData = vecs[v].wdata;
         ReadRegister1 = vecs[v].ra1;
         ReadRegister2 = vecs[v].ra2;
         #1;
         check($sformatf("vec%0d pre rd1", v), rd1, vecs[v].pre1);
         check($sformatf("vec%0d pre rd2", v), rd2, vecs[v].pre2);
         check($sformatf("vec%0d byp rd1", v), bp1, vecs[v].byp1);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d post rd1", v), rd1, vecs[v].post1);
         check($sformatf("vec%0d post rd2", v), rd2, vecs[v].post2);
         RegWrite = 1'b0;
         if (vecs[v].we && vecs[v].waddr != 5'd31) model[vecs[v].waddr] = vecs[v].wdata;
         $display("vec %0d: we=%0b X%0d<=%h rd1=%h rd2=%h", v, vecs[v].we, vecs[v].waddr,
                  vecs[v].wdata, rd1, rd2);
      end
      check_all("table");

      // Unknown write address with RegWrite=0 must not disturb anything
      @(negedge clk);
      RegWrite = 1'b0;
      WriteRegister = 'x;
      WriteData = 64'h0BAD_0BAD_0BAD_0BAD;
      @(posedge clk);
      #1;
      WriteRegister = '0;
      check_all("xaddr");

      // Reset and write on the same edge: reset wins, the following write lands
      @(negedge clk);
      reset = 1'b1;
      RegWrite = 1'b1;
      WriteRegister = 5'd3;
      WriteData = 64'hDEAD_BEEF;
      ReadRegister1 = 5'd3;
      ReadRegister2 = 5'd7;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst+wr X3", rd1, 64'd0);
      check("rst+wr X7", rd2, 64'd0);
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      check("post-rst wr X3", rd1, 64'hDEAD_BEEF);
      $display("reset+write: X3 now %h", rd1);
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[3] = 64'hDEAD_BEEF;
      check_all("after reset");

      // Back-to-back writes to X10 with neighbours holding their values
      do_write(5'd9, 64'h99);
      do_write(5'd11, 64'hBB);
      @(negedge clk);
      RegWrite = 1'b1;
      WriteRegister = 5'd10;
      ReadRegister1 = 5'd10;
      ReadRegister2 = 5'd9;
      for (int k = 1; k <= 3; k++) begin
         WriteData = 64'(k);
         @(posedge clk);
         #1;
         check($sformatf("b2b%0d X10", k), rd1, 64'(k));
         check($sformatf("b2b%0d X9", k), rd2, 64'h99);
         $display("b2b write %0d: X10=%h", k, rd1);
      end
      RegWrite = 1'b0;
      ReadRegister2 = 5'd11;
      #1;
      check("b2b X11", rd2, 64'hBB);
      model[9] = 64'h99;
      model[10] = 64'h3;
      model[11] = 64'hBB;
      check_all("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
